// File: rtl/icb_mem_slave_if.sv
// ICB command/response bundle between the load/store unit (master) and a memory
// responder (slave).
interface icb_mem_slave_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 32
);
    logic                   icb_cmd_valid;
    logic                   icb_cmd_ready;
    logic [ADDR_SIZE-1:0]   icb_cmd_addr;
    logic                   icb_cmd_read;
    logic [XLEN-1:0]        icb_cmd_wdata;
    logic [XLEN/8-1:0]      icb_cmd_wmask;
    logic                   icb_rsp_valid;
    logic                   icb_rsp_ready;
    logic [XLEN-1:0]        icb_rsp_rdata;
    logic                   icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/icb_mem_slave.sv
// ICB memory responder: one outstanding command, word read or byte-masked write on an
// internal synchronous array, response returned after a fixed programmable latency.
module icb_mem_slave #(
    parameter int unsigned          XLEN       = 32,
    parameter int unsigned          ADDR_SIZE  = 32,
    parameter int unsigned          DEPTH_LOG2 = 10,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned          LATENCY    = 2
) (
    input  logic           clk,
    input  logic           rst,
    icb_mem_slave_if.slave icb
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    // Byte span of the array, one bit wider than the address so it cannot overflow.
    localparam logic [ADDR_SIZE:0] Span = {{ADDR_SIZE{1'b0}}, 1'b1} << (DEPTH_LOG2 + 2);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]     rdata_q;
    logic                err_q;
    logic [XLEN-1:0]     mem [Depth];

    logic [ADDR_SIZE-1:0]  off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  cmd_fire;
    logic                  rsp_fire;

    assign off      = icb.icb_cmd_addr - BASE_ADDR;
    assign in_range = (icb.icb_cmd_addr >= BASE_ADDR) && ({1'b0, off} < Span);
    assign idx      = off[DEPTH_LOG2+1:2];
    assign cmd_fire = icb.icb_cmd_valid && icb.icb_cmd_ready;
    assign rsp_fire = icb.icb_rsp_valid && icb.icb_rsp_ready;

    assign icb.icb_rsp_rdata = rdata_q;
    assign icb.icb_rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(LATENCY - 2);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (rsp_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready depends on state and reset only, never on cmd_valid.
    always_comb begin
        icb.icb_cmd_ready = 1'b0;
        icb.icb_rsp_valid = 1'b0;
        unique case (state_q)
            StIdle:  icb.icb_cmd_ready = !rst;
            StResp:  icb.icb_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (cmd_fire) begin
            err_q   <= !in_range;
            rdata_q <= (icb.icb_cmd_read && in_range) ? mem[idx] : '0;
        end
    end

    // Array has no reset; writes committed before a reset survive it.
    always_ff @(posedge clk) begin
        if (cmd_fire && !icb.icb_cmd_read && in_range) begin
            for (int i = 0; i < int'(XLEN / 8); i++) begin
                if (icb.icb_cmd_wmask[i]) begin
                    mem[idx][8*i +: 8] <= icb.icb_cmd_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
